// File: rtl/dvi_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder; combinational only.
// No state, no latency, no flow control.
package dvi_pkg;
  localparam int TMDS_W = 10;
  localparam int CNT_W  = 5;

  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition minimise then DC balance, 2-cycle latency.
// Free-running at pixel rate; no backpressure, one symbol per clock.
module tmds_channel_encoder
  import dvi_pkg::*;
(
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic [7:0]        d,
  input  logic [1:0]        c,
  input  logic              de,
  output logic [TMDS_W-1:0] q
);

  logic [3:0]              n1d;
  logic                    use_xnor;
  logic [8:0]              q_m_d, q_m_q;
  logic [3:0]              n1q_d, n1q_q;
  logic                    de_q;
  logic [1:0]              c_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [TMDS_W-1:0]       q_d, q_q;
  logic [CNT_W-1:0]        bal, qm8x2;

  always_comb begin
    n1d      = popcount8(d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    q_m_d    = '0;
    q_m_d[0] = d[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d[i]) : (q_m_d[i-1] ^ d[i]);
    q_m_d[8] = ~use_xnor;
    n1q_d    = popcount8(q_m_d[7:0]);
  end

  // bal is n1q-n0q; all disparity arithmetic is modulo 2^CNT_W and never leaves +/-10
  always_comb begin
    bal   = {n1q_q, 1'b0} - 5'd8;
    qm8x2 = {3'b000, q_m_q[8], 1'b0};
    q_d   = TMDS_CTRL_00;
    cnt_d = cnt_q;
    if (!de_q) begin
      cnt_d = '0;
      case (c_q)
        2'b00:   q_d = TMDS_CTRL_00;
        2'b01:   q_d = TMDS_CTRL_01;
        2'b10:   q_d = TMDS_CTRL_10;
        default: q_d = TMDS_CTRL_11;
      endcase
    end else if ((cnt_q == '0) || (n1q_q == 4'd4)) begin
      q_d   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      cnt_d = q_m_q[8] ? (cnt_q + bal) : (cnt_q - bal);
    end else if (((cnt_q > 5'sd0) && (n1q_q > 4'd4)) ||
                 ((cnt_q < 5'sd0) && (n1q_q < 4'd4))) begin
      q_d   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      cnt_d = cnt_q + qm8x2 - bal;
    end else begin
      q_d   = {1'b0, q_m_q[8], q_m_q[7:0]};
      cnt_d = cnt_q + bal - (q_m_q[8] ? 5'd0 : 5'd2);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      q_m_q <= '0;
      n1q_q <= '0;
      de_q  <= 1'b0;
      c_q   <= '0;
      cnt_q <= '0;
      q_q   <= TMDS_CTRL_00;
    end else begin
      q_m_q <= q_m_d;
      n1q_q <= n1q_d;
      de_q  <= de;
      c_q   <= c;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder, latency 2+INPUT_REG pixel clocks, all channels aligned.
// No backpressure: accepts one pixel every clk_pixel and emits three symbols every clock.
module dvi_tmds_encoder
  import dvi_pkg::*;
#(
  parameter int INPUT_REG = 1
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  input  logic              de,
  input  logic              hsync,
  input  logic              vsync,
  output logic [TMDS_W-1:0] tmds_internal0,
  output logic [TMDS_W-1:0] tmds_internal1,
  output logic [TMDS_W-1:0] tmds_internal2
);

  logic [7:0] red_s, green_s, blue_s;
  logic       de_s, hsync_s, vsync_s;

  generate
    if (INPUT_REG != 0) begin : g_in_reg
      logic [7:0] red_q, green_q, blue_q;
      logic       de_q, hsync_q, vsync_q;

      always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
          de_q    <= 1'b0;
          hsync_q <= 1'b0;
          vsync_q <= 1'b0;
        end else begin
          red_q   <= red;
          green_q <= green;
          blue_q  <= blue;
          de_q    <= de;
          hsync_q <= hsync;
          vsync_q <= vsync;
        end
      end

      assign red_s   = red_q;
      assign green_s = green_q;
      assign blue_s  = blue_q;
      assign de_s    = de_q;
      assign hsync_s = hsync_q;
      assign vsync_s = vsync_q;
    end else begin : g_no_reg
      assign red_s   = red;
      assign green_s = green;
      assign blue_s  = blue;
      assign de_s    = de;
      assign hsync_s = hsync;
      assign vsync_s = vsync;
    end
  endgenerate

  // Only the blue channel carries sync; green and red idle on control 00
  tmds_channel_encoder u_ch0 (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .d         (blue_s),
    .c         ({vsync_s, hsync_s}),
    .de        (de_s),
    .q         (tmds_internal0)
  );

  tmds_channel_encoder u_ch1 (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .d         (green_s),
    .c         (2'b00),
    .de        (de_s),
    .q         (tmds_internal1)
  );

  tmds_channel_encoder u_ch2 (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .d         (red_s),
    .c         (2'b00),
    .de        (de_s),
    .q         (tmds_internal2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
`timescale 1ns/100ps
module tb_dvi_tmds_encoder;
  localparam int INPUT_REG = 1;
  localparam int LAT       = 2 + INPUT_REG;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b1;
  logic [7:0] red = 8'h00, green = 8'h00, blue = 8'h00;
  logic       de = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [9:0] tmds_internal0, tmds_internal1, tmds_internal2;

  typedef struct {
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
    logic       de;
  } exp_t;

  exp_t sb[$];
  int   mcnt[3];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_pixel = ~clk_pixel;

  dvi_tmds_encoder #(.INPUT_REG(INPUT_REG)) dut (
    .clk_pixel      (clk_pixel),
    .reset_n        (reset_n),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .de             (de),
    .hsync          (hsync),
    .vsync          (vsync),
    .tmds_internal0 (tmds_internal0),
    .tmds_internal1 (tmds_internal1),
    .tmds_internal2 (tmds_internal2)
  );

  // Behavioural TMDS encoder, one running disparity per channel
  function automatic logic [9:0] model_enc(input int ch, input logic [7:0] d,
                                           input logic [1:0] c, input logic den);
    logic [8:0] qm;
    logic       xn;
    int         n1, n1q, n0q;
    logic [9:0] o;
    if (!den) begin
      mcnt[ch] = 0;
      case (c)
        2'd0:    return C00;
        2'd1:    return C01;
        2'd2:    return C10;
        default: return C11;
      endcase
    end
    n1    = $countones(d);
    xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    n1q   = $countones(qm[7:0]);
    n0q   = 8 - n1q;
    if (mcnt[ch] == 0 || n1q == n0q) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((mcnt[ch] > 0 && n1q > n0q) || (mcnt[ch] < 0 && n0q > n1q)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      mcnt[ch] += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      mcnt[ch] += n1q - n0q - (qm[8] ? 0 : 2);
    end
    return o;
  endfunction

  task automatic push_model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic d, input logic hs, input logic vs);
    exp_t e;
    red = r; green = g; blue = b; de = d; hsync = hs; vsync = vs;
    e.e0 = model_enc(0, b, {vs, hs}, d);
    e.e1 = model_enc(1, g, 2'b00, d);
    e.e2 = model_enc(2, r, 2'b00, d);
    e.de = d;
    sb.push_back(e);
  endtask

  task automatic push_const(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic d, input logic hs, input logic vs,
                            input logic [9:0] x0, input logic [9:0] x1, input logic [9:0] x2);
    exp_t e;
    red = r; green = g; blue = b; de = d; hsync = hs; vsync = vs;
    void'(model_enc(0, b, {vs, hs}, d));
    void'(model_enc(1, g, 2'b00, d));
    void'(model_enc(2, r, 2'b00, d));
    e.e0 = x0; e.e1 = x1; e.e2 = x2; e.de = d;
    sb.push_back(e);
  endtask

  // Pipeline content right after a reset release: LAT control-00 symbols
  task automatic prefill();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    e.e0 = C00; e.e1 = C00; e.e2 = C00; e.de = 1'b0;
    for (int i = 0; i < LAT; i++) sb.push_back(e);
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {C00, C00, C00}) begin
      failures++;
      $display("FAIL reset_async got %h/%h/%h want %h", tmds_internal0, tmds_internal1,
               tmds_internal2, C00);
    end
    repeat (3) @(posedge clk_pixel);
    #1;
    checks++;
    if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {C00, C00, C00}) begin
      failures++;
      $display("FAIL reset_held got %h/%h/%h want %h", tmds_internal0, tmds_internal1,
               tmds_internal2, C00);
    end
    reset_n = 1'b1;
    prefill();
  endtask

  task automatic test_control();
    logic [1:0] vh[4];
    logic [9:0] c0[4];
    exp_t       e;
    vh[0] = 2'b00; vh[1] = 2'b01; vh[2] = 2'b11; vh[3] = 2'b10;
    c0[0] = C00;   c0[1] = C01;   c0[2] = C11;   c0[3] = C10;
    for (int k = 0; k < 4 * (LAT + 1); k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL control step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      push_const(8'h00, 8'h00, 8'h00, 1'b0, vh[k/(LAT+1)][0], vh[k/(LAT+1)][1],
                 c0[k/(LAT+1)], C00, C00);
    end
  endtask

  task automatic test_zero_run();
    logic [9:0] ex[6];
    logic [7:0] px;
    logic       dv;
    exp_t       e;
    ex[0] = C00; ex[1] = C00; ex[2] = 10'h100; ex[3] = 10'h3FF; ex[4] = 10'h100; ex[5] = 10'h3FF;
    for (int k = 0; k < 6 + LAT; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL zero_run step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      dv = (k >= 2 && k < 6);
      px = 8'h00;
      if (k < 6) push_const(px, px, px, dv, 1'b0, 1'b0, ex[k], ex[k], ex[k]);
      else       push_const(px, px, px, 1'b0, 1'b0, 1'b0, C00, C00, C00);
    end
  endtask

  task automatic test_ff_run();
    logic [9:0] ex[4];
    exp_t       e;
    ex[0] = C00; ex[1] = C00; ex[2] = 10'h200; ex[3] = 10'h0FF;
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL ff_run step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      if (k < 4) push_const(8'hFF, 8'hFF, 8'hFF, (k >= 2), 1'b0, 1'b0, ex[k], ex[k], ex[k]);
      else       push_const(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, C00, C00, C00);
    end
  endtask

  task automatic test_de_gap();
    logic [9:0] ex[7];
    logic       dv[7];
    exp_t       e;
    ex[0] = C00;     ex[1] = 10'h100; ex[2] = 10'h3FF; ex[3] = 10'h100;
    ex[4] = C00;     ex[5] = 10'h100; ex[6] = 10'h3FF;
    dv[0] = 1'b0; dv[1] = 1'b1; dv[2] = 1'b1; dv[3] = 1'b1;
    dv[4] = 1'b0; dv[5] = 1'b1; dv[6] = 1'b1;
    for (int k = 0; k < 7 + LAT; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL de_gap step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      if (k < 7) push_const(8'h00, 8'h00, 8'h00, dv[k], 1'b0, 1'b0, ex[k], ex[k], ex[k]);
      else       push_const(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, C00, C00, C00);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   disp[3];
    int   worst;
    worst = 0;
    for (int i = 0; i < 3; i++) disp[i] = 0;
    for (int k = 0; k < 10000 + 2 + LAT; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL random step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      if (e.de) begin
        disp[0] += 2 * $countones(tmds_internal0) - 10;
        disp[1] += 2 * $countones(tmds_internal1) - 10;
        disp[2] += 2 * $countones(tmds_internal2) - 10;
        for (int i = 0; i < 3; i++) begin
          if (disp[i] > worst)  worst = disp[i];
          if (-disp[i] > worst) worst = -disp[i];
        end
      end else begin
        for (int i = 0; i < 3; i++) disp[i] = 0;
      end
      if (k < 2 || k >= 10002)
        push_model(8'h00, 8'h00, 8'h00, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      else
        push_model(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (worst > 10) begin
      failures++;
      $display("FAIL random_disparity got max |disparity|=%0d want <=10", worst);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL async_pre step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      push_model(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1);
    end
    @(posedge clk_pixel);
    #2 reset_n = 1'b0;
    #0.5;
    checks++;
    if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {C00, C00, C00}) begin
      failures++;
      $display("FAIL async_reset got %h/%h/%h want %h", tmds_internal0, tmds_internal1,
               tmds_internal2, C00);
    end
    #0.5 reset_n = 1'b1;
    prefill();
    for (int k = 0; k < 3 + LAT; k++) begin
      @(negedge clk_pixel);
      e = sb.pop_front();
      checks++;
      if ({tmds_internal2, tmds_internal1, tmds_internal0} !== {e.e2, e.e1, e.e0}) begin
        failures++;
        $display("FAIL async_post step=%0d got %h/%h/%h want %h/%h/%h", k, tmds_internal0,
                 tmds_internal1, tmds_internal2, e.e0, e.e1, e.e2);
      end
      if (k == 0)      push_const(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 10'h100, 10'h100, 10'h100);
      else if (k == 1) push_model(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
      else             push_model(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_control();
    test_zero_run();
    test_ff_run();
    test_de_gap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
